// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring integer divider with valid/ready handshakes,
// flush, optional early-out on small dividends and defined divide-by-zero results.
package div_iter_pkg;
   typedef enum logic [1:0] {
      DIV_DIV  = 2'd0,
      DIV_DIVU = 2'd1,
      DIV_MOD  = 2'd2,
      DIV_MODU = 2'd3
   } div_opcode_t;
endpackage

module div_iter
   import div_iter_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter bit          EARLY_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  div_opcode_t      opcode,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t           state, state_nx;
   div_opcode_t      op_q;
   logic [WIDTH-1:0] a_q, d_q, dvd_q, res_q;
   logic [WIDTH:0]   rem_q;
   logic [CW-1:0]    cnt_q;
   logic             qsign_q, rsign_q;

   logic             signed_op, is_div, accept, q_bit;
   logic [WIDTH-1:0] abs_a, abs_d, rem_lo;
   logic [CW-1:0]    lz, n_iter;
   logic [WIDTH:0]   rem_sh, d_ext, diff;

   function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] x);
      lzc = CW'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (x[i]) lzc = CW'(WIDTH - 1 - i);
      end
   endfunction

   assign signed_op = (op_q == DIV_DIV) || (op_q == DIV_MOD);
   assign is_div    = (op_q == DIV_DIV) || (op_q == DIV_DIVU);
   assign accept    = in_valid && (state == IDLE) && !flush;

   // Until PREP completes, a_q/d_q hold the raw operands; d_q becomes |src2| afterwards.
   assign abs_a  = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
   assign abs_d  = (signed_op && d_q[WIDTH-1]) ? -d_q : d_q;
   assign lz     = lzc(abs_a);
   assign n_iter = EARLY_OUT ? CW'(WIDTH) - lz : CW'(WIDTH);

   assign rem_sh = (WIDTH + 1)'({rem_q, dvd_q[WIDTH-1]});
   assign d_ext  = {1'b0, d_q};
   assign diff   = rem_sh - d_ext;
   assign q_bit  = (rem_sh >= d_ext);
   assign rem_lo = rem_q[WIDTH-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      if (flush) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: if (in_valid) state_nx = PREP;
            PREP: state_nx = ((abs_d == '0) || (n_iter == '0)) ? FIX : CALC;
            CALC: if (cnt_q == CW'(1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // dvd_q doubles as the quotient register: dividend bits shift out the top
   // while quotient bits shift in at the bottom.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q    <= DIV_DIV;
         a_q     <= '0;
         d_q     <= '0;
         dvd_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         res_q   <= '0;
      end else begin
         if (accept) begin
            op_q <= opcode;
            a_q  <= src1;
            d_q  <= src2;
         end
         case (state)
            PREP: begin
               d_q     <= abs_d;
               dvd_q   <= EARLY_OUT ? (abs_a << lz) : abs_a;
               rem_q   <= '0;
               cnt_q   <= n_iter;
               qsign_q <= signed_op && (a_q[WIDTH-1] ^ d_q[WIDTH-1]);
               rsign_q <= signed_op && a_q[WIDTH-1];
            end
            CALC: begin
               rem_q <= q_bit ? diff : rem_sh;
               dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
               cnt_q <= cnt_q - CW'(1);
            end
            FIX: begin
               if (d_q == '0)  res_q <= is_div ? '1 : a_q;
               else if (is_div) res_q <= qsign_q ? -dvd_q : dvd_q;
               else             res_q <= rsign_q ? -rem_lo : rem_lo;
            end
            default: ;
         endcase
      end
   end

   assign result = res_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: a 32-bit early-out instance and an 8-bit
// fixed-iteration instance, plus handshake, flush and async-reset sequences.
module tb_div_iter;
   import div_iter_pkg::*;

   logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
   div_opcode_t opcode = DIV_DIVU;
   logic [31:0] src1 = '0, src2 = '0, result;

   logic        in_valid_b = 1'b0, out_ready_b = 1'b0, in_ready_b, out_valid_b;
   div_opcode_t opcode_b = DIV_DIVU;
   logic [7:0]  src1_b = '0, src2_b = '0, result_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_iter #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .src1(src1), .src2(src2),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   div_iter #(.WIDTH(8), .EARLY_OUT(1'b0)) dut_b (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .opcode(opcode_b),
      .src1(src1_b), .src2(src2_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .result(result_b)
   );

   typedef struct {
      bit          narrow;
      div_opcode_t op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Latency = number of rising edges after the accept edge until out_valid is seen.
   task automatic run(input bit narrow, input div_opcode_t op, input logic [31:0] a,
                      input logic [31:0] b, output logic [31:0] res, output int lat);
      @(negedge clk);
      if (narrow) begin
         opcode_b = op; src1_b = a[7:0]; src2_b = b[7:0]; in_valid_b = 1'b1;
      end else begin
         opcode = op; src1 = a; src2 = b; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid_b = 1'b0;
      lat = 0;
      while (!(narrow ? out_valid_b : out_valid) && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      res = narrow ? {24'd0, result_b} : result;
      @(negedge clk);
      out_ready = 1'b1; out_ready_b = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; out_ready_b = 1'b0;
   endtask

   function automatic logic [31:0] model(input div_opcode_t op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [31:0] sa, sb;
      bit is_div;
      is_div = (op == DIV_DIV) || (op == DIV_DIVU);
      sa = a; sb = b;
      if (b == 0) return is_div ? 32'hFFFF_FFFF : a;
      if (op == DIV_DIVU) return a / b;
      if (op == DIV_MODU) return a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_div ? a : 32'd0;
      return is_div ? 32'(sa / sb) : 32'(sa % sb);
   endfunction

   function automatic int model_lat(input div_opcode_t op, input logic [31:0] a,
                                    input logic [31:0] b);
      logic [31:0] m;
      int n;
      m = ((op == DIV_DIV || op == DIV_MOD) && a[31]) ? -a : a;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return (b == 0 || n == 0) ? 2 : 2 + n;
   endfunction

   initial begin
      logic [31:0] res;
      int lat, w, seen;

      vecs.push_back(vec_t'{1'b0, DIV_DIVU, 32'd100, 32'd7, 32'd14, 9, "divu_100_7"});
      vecs.push_back(vec_t'{1'b0, DIV_MODU, 32'd100, 32'd7, 32'd2, 9, "modu_100_7"});
      vecs.push_back(vec_t'{1'b0, DIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5, "div_m7_2"});
      vecs.push_back(vec_t'{1'b0, DIV_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 5, "mod_m7_2"});
      vecs.push_back(vec_t'{1'b0, DIV_MOD, 32'd7, 32'hFFFF_FFFE, 32'd1, 5, "mod_7_m2"});
      vecs.push_back(vec_t'{1'b0, DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "div_min_m1"});
      vecs.push_back(vec_t'{1'b0, DIV_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "mod_min_m1"});
      vecs.push_back(vec_t'{1'b0, DIV_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max_1"});
      vecs.push_back(vec_t'{1'b0, DIV_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "divu_5_0"});
      vecs.push_back(vec_t'{1'b0, DIV_MOD, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, "mod_m5_0"});
      vecs.push_back(vec_t'{1'b0, DIV_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "div_5_0"});
      vecs.push_back(vec_t'{1'b0, DIV_DIV, 32'd0, 32'd5, 32'd0, 2, "div_0_5"});
      vecs.push_back(vec_t'{1'b0, DIV_MODU, 32'd0, 32'd0, 32'd0, 2, "modu_0_0"});
      vecs.push_back(vec_t'{1'b0, DIV_DIVU, 32'd1, 32'd1, 32'd1, 3, "divu_1_1"});
      vecs.push_back(vec_t'{1'b0, DIV_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 9, "div_m100_7"});
      vecs.push_back(vec_t'{1'b0, DIV_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 9, "div_100_m7"});
      vecs.push_back(vec_t'{1'b0, DIV_MOD, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 9, "mod_m100_m7"});
      vecs.push_back(vec_t'{1'b1, DIV_DIVU, 32'd0, 32'd5, 32'd0, 10, "w8_divu_0_5"});
      vecs.push_back(vec_t'{1'b1, DIV_DIVU, 32'd200, 32'd7, 32'd28, 10, "w8_divu_200_7"});
      vecs.push_back(vec_t'{1'b1, DIV_MODU, 32'd200, 32'd7, 32'd4, 10, "w8_modu_200_7"});
      vecs.push_back(vec_t'{1'b1, DIV_DIV, 32'h80, 32'hFF, 32'h80, 10, "w8_div_min_m1"});
      vecs.push_back(vec_t'{1'b1, DIV_DIV, 32'hF9, 32'd2, 32'hFD, 10, "w8_div_m7_2"});
      vecs.push_back(vec_t'{1'b1, DIV_MOD, 32'hF9, 32'd2, 32'hFF, 10, "w8_mod_m7_2"});
      vecs.push_back(vec_t'{1'b1, DIV_DIVU, 32'd5, 32'd0, 32'hFF, 2, "w8_divu_5_0"});

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_result_w8", 32'(result_b), 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      foreach (vecs[i]) begin
         chk({vecs[i].name, "_idle"},
             32'(vecs[i].narrow ? in_ready_b : in_ready), 32'd1);
         run(vecs[i].narrow, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
         chk(vecs[i].name, res, vecs[i].exp);
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      end

      for (int i = 0; i < 40; i++) begin
         div_opcode_t op;
         logic [31:0] a, b;
         op = div_opcode_t'($urandom_range(0, 3));
         a = $urandom;
         if (i % 3 == 0) a = a >> $urandom_range(0, 31);
         b = (i % 7 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         run(1'b0, op, a, b, res, lat);
         chk($sformatf("rnd%0d_%s_%08h_%08h", i, op.name(), a, b), res, model(op, a, b));
         chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(model_lat(op, a, b)));
      end

      // Back-pressure: result held while out_ready is low
      @(negedge clk);
      opcode = DIV_DIVU; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 60) begin @(posedge clk); #1; w++; end
      chk("hold_lat", 32'(w), 32'd9);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("hold_result", result, 32'd14);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);

      // Flush in IDLE blocks acceptance
      @(negedge clk);
      opcode = DIV_DIVU; src1 = 32'd9; src2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_idle_no_accept", 32'(in_ready), 32'd1);

      // Flush three cycles into CALC
      @(negedge clk);
      opcode = DIV_DIVU; src1 = 32'hFFFF_FFFF; src2 = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_calc_in_ready", 32'(in_ready), 32'd1);
      chk("flush_calc_out_valid", 32'(out_valid), 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("flush_calc_no_result", 32'(seen), 32'd0);
      run(1'b0, DIV_DIVU, 32'd9, 32'd3, res, lat);
      chk("after_flush_divu_9_3", res, 32'd3);
      chk("after_flush_lat", 32'(lat), 32'd6);

      // Flush while DONE discards the pending result
      @(negedge clk);
      opcode = DIV_DIVU; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 60) begin @(posedge clk); #1; w++; end
      chk("done_flush_pre_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("done_flush_out_valid", 32'(out_valid), 32'd0);
      chk("done_flush_in_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset mid-CALC, observed before any clock edge
      @(negedge clk);
      opcode = DIV_DIVU; src1 = 32'hFFFF_FFFF; src2 = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1 resetn = 1'b0;
      #1;
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_result", result, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("async_rst_no_result", 32'(seen), 32'd0);
      run(1'b0, DIV_MODU, 32'd100, 32'd7, res, lat);
      chk("after_rst_modu", res, 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
